// File: rtl/dac_level_rx.sv
// Receive side of the 4-lane serial DAC level link.
// Frames on cs_n, shifts four MSB-first lanes, strobes levels.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   i_dac_cs_n           frame select, active low
//   i_dac_data_0..3      serial lanes, MSB first
//   o_level_0..3         last good levels (DATA_W), held
//   o_valid              1-cycle pulse on level update
//   o_frame_err          1-cycle pulse on bad frame
//   o_busy               high while shifting a frame
//   o_frame_cnt          good-frame counter, wraps
//
// Optional: define DAC_RX_TIMEOUT_EN to enable the
// cs_n-low watchdog (limit set by TIMEOUT).
module dac_level_rx #(
   parameter int FRAME_W = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_dac_cs_n,
   input  logic              i_dac_data_0,
   input  logic              i_dac_data_1,
   input  logic              i_dac_data_2,
   input  logic              i_dac_data_3,
   output logic [DATA_W-1:0] o_level_0,
   output logic [DATA_W-1:0] o_level_1,
   output logic [DATA_W-1:0] o_level_2,
   output logic [DATA_W-1:0] o_level_3,
   output logic              o_valid,
   output logic              o_frame_err,
   output logic              o_busy,
   output logic [15:0]       o_frame_cnt
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam int CW = $clog2(FRAME_W + 2);
   localparam logic [CW-1:0] FULL = CW'(FRAME_W);
   localparam logic [CW-1:0] SAT  = CW'(FRAME_W + 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ovr_q, ovr_d;
   logic prev_cs_n;
   logic fall;
   logic [3:0] lanes;
   logic [FRAME_W-1:0] sr_q [4];
   logic [FRAME_W-1:0] sr_d [4];
   logic [DATA_W-1:0] lvl_q [4];
   logic [DATA_W-1:0] lvl_d [4];
   logic valid_d, err_d;
   logic [15:0] fcnt_d;

`ifdef DAC_RX_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 2);
   localparam logic [WW-1:0] WD_ONE = WW'(1);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);
   logic [WW-1:0] wd_q, wd_d;
`endif

   assign lanes = {i_dac_data_3, i_dac_data_2,
                   i_dac_data_1, i_dac_data_0};

   // prev_cs_n resets low so a cs_n already low at
   // reset release is not taken as a frame start.
   assign fall = prev_cs_n & ~i_dac_cs_n;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      sr_d    = sr_q;
      lvl_d   = lvl_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      fcnt_d  = o_frame_cnt;
`ifdef DAC_RX_TIMEOUT_EN
      wd_d    = wd_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = SHIFT;
               for (int k = 0; k < 4; k++)
                  sr_d[k] = (sr_q[k] << 1)
                          | FRAME_W'(lanes[k]);
               cnt_d = ONE;
               ovr_d = 1'b0;
`ifdef DAC_RX_TIMEOUT_EN
               wd_d  = WD_ONE;
`endif
            end
         end
         SHIFT: begin
            if (!i_dac_cs_n) begin
               for (int k = 0; k < 4; k++)
                  sr_d[k] = (sr_q[k] << 1)
                          | FRAME_W'(lanes[k]);
               if (cnt_q == FULL) ovr_d = 1'b1;
               if (cnt_q != SAT) cnt_d = cnt_q + ONE;
`ifdef DAC_RX_TIMEOUT_EN
               // Abort once; a fresh falling edge is
               // needed before the next frame.
               wd_d = wd_q + WD_ONE;
               if (wd_d >= WD_MAX) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
                  ovr_d   = 1'b0;
               end
`endif
            end else begin
               if (cnt_q == FULL && !ovr_q) begin
                  for (int k = 0; k < 4; k++)
                     lvl_d[k] = sr_q[k][DATA_W-1:0];
                  valid_d = 1'b1;
                  fcnt_d  = o_frame_cnt + 16'd1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
               cnt_d   = '0;
               ovr_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ovr_q       <= 1'b0;
         prev_cs_n   <= 1'b0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_frame_cnt <= '0;
         for (int k = 0; k < 4; k++) begin
            sr_q[k]  <= '0;
            lvl_q[k] <= '0;
         end
`ifdef DAC_RX_TIMEOUT_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ovr_q       <= ovr_d;
         prev_cs_n   <= i_dac_cs_n;
         o_valid     <= valid_d;
         o_frame_err <= err_d;
         o_frame_cnt <= fcnt_d;
         for (int k = 0; k < 4; k++) begin
            sr_q[k]  <= sr_d[k];
            lvl_q[k] <= lvl_d[k];
         end
`ifdef DAC_RX_TIMEOUT_EN
         wd_q        <= wd_d;
`endif
      end
   end

   assign o_busy    = (state_q == SHIFT);
   assign o_level_0 = lvl_q[0];
   assign o_level_1 = lvl_q[1];
   assign o_level_2 = lvl_q[2];
   assign o_level_3 = lvl_q[3];

endmodule

// File: doc/dac_level_rx.md
Name: dac_level_rx

Overview:
- Receiving end of the 4-lane serial DAC level link.
- Frames on i_dac_cs_n, deserialises four MSB-first lanes in parallel and presents the four level bytes with a one-cycle valid strobe.
- Sits on the DAC side of the board, or in loopback as a checker for the level transmitter.
- Also reports malformed frames and counts good frames.

Parameters:
- FRAME_W, 8, bits per lane per frame (must be ≥ DATA_W, ≤ 32).
- DATA_W, 8, level width; the level is the last DATA_W bits shifted in.
- TIMEOUT, 255, maximum cs_n-low cycles; used only with DAC_RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- i_dac_cs_n  in  1  frame select, active low.
- i_dac_data_0..i_dac_data_3  in  1 each  serial lanes 0..3, MSB first.
- o_level_0..o_level_3  out  DATA_W each  last good levels, held between frames.
- o_valid  out  1  one-cycle pulse when o_level_* updated.
- o_frame_err  out  1  one-cycle pulse on short/long/timed-out frame.
- o_busy  out  1  high while in SHIFT.
- o_frame_cnt  out  16  good-frame counter, wraps 0xFFFF→0.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, bit_cnt=0, shift regs=0, o_level_*=0.
  - o_valid=0, o_frame_err=0, o_busy=0, o_frame_cnt=0.
  - prev_cs_n=0, so cs_n already low at reset release is not a falling edge.
- prev_cs_n registers i_dac_cs_n every clk. Falling edge = prev_cs_n & ~i_dac_cs_n.
- IDLE:
  - On falling edge → SHIFT.
  - Lane bits are sampled in that same cycle; bit_cnt=1.
  - All other cycles: hold.
- SHIFT, cs_n low:
  - Each lane shift reg <= {sr[FRAME_W-2:0], lane}; bit_cnt+1 (saturates at FRAME_W+1).
  - If bit_cnt is already FRAME_W when a further low cycle is seen → overrun flag set; shifting continues, with no effect on outcome.
- SHIFT, cs_n high (end of frame):
  - Good frame (bit_cnt==FRAME_W and no overrun): o_level_k <= sr_k[DATA_W-1:0]; o_valid=1 next cycle; o_frame_cnt+1.
  - Otherwise: o_frame_err=1 next cycle; o_level_* unchanged.
  - Either way → IDLE, bit_cnt=0, overrun cleared.
- Latency:
  - Last data bit at cycle N, cs_n high at N+1, o_valid/o_level at N+2.
  - A new falling edge at N+2 is accepted; minimum cs_n high time is 1 cycle.
- o_busy = (state==SHIFT).
- o_valid and o_frame_err are never high in the same cycle. Each is high for exactly 1 cycle.
- Reset mid-frame: frame discarded, no valid, no error.
- Glitch: cs_n low for 1 cycle with FRAME_W>1 → frame_err.

Optional Feature:
- Macro: DAC_RX_TIMEOUT_EN.
- Defined:
  - A watchdog counts SHIFT cycles.
  - When it reaches TIMEOUT with cs_n still low: o_frame_err pulses, state → IDLE, o_level_* unchanged.
  - The block then waits for a fresh falling edge, so cs_n stuck low yields exactly one error.
- Undefined:
  - No watchdog.
  - A stuck-low cs_n keeps the block in SHIFT (overrun) until cs_n rises, then one frame_err.

Test Plan:
- Defaults; cs_n low 8 cycles with lanes 0xA5, 0x3C, 0xFF, 0x01 MSB first, then high → o_level = A5/3C/FF/01 two cycles after last bit; o_valid one cycle; o_frame_cnt=1.
- cs_n low only 7 cycles → o_frame_err one cycle; o_level keeps prior values; o_frame_cnt unchanged.
- cs_n low 9 cycles → o_frame_err; no o_valid.
- Back-to-back frames 0x11.. and 0x22.. with 1-cycle cs_n high gap → two o_valid pulses; levels 0x22 on all lanes; o_frame_cnt=2.
- Assert rst at bit 4 of a frame, release with cs_n still low, finish the frame → no valid, no error. Next clean frame 0x5A → accepted.
- With DAC_RX_TIMEOUT_EN and TIMEOUT=20, hold cs_n low 50 cycles → single o_frame_err at cycle 20; o_busy drops; no further error until cs_n rises and falls again.
- o_frame_cnt preset path: 65536 good frames → counter wraps to 0.
